operand_mat_streamer: RTL

//   Read-side sequencer for one operand matrix register file. On start it walks
//   an n_rows x n_cols sub-matrix, drives the read address and captures the

---
 rtl/operand_mat_streamer_if.sv | 23 ++
 rtl/operand_mat_streamer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/operand_mat_streamer_if.sv
// Register-file read port plus element stream for operand_mat_streamer.
// master = streamer side; slave = register file / multiply datapath side.
interface operand_mat_streamer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_row_last;
  logic                  m_last;

  modport master (
    output rd_addr, input rd_data,
    output m_valid, input m_ready, output m_data, m_row_last, m_last
  );
  modport slave (
    input rd_addr, output rd_data,
    input m_valid, output m_ready, input m_data, m_row_last, m_last
  );
endinterface

// File: rtl/operand_mat_streamer.sv
// Walks an n_rows x n_cols sub-matrix of the operand register file and streams it out.
// Optional TRANSPOSE_EN macro enables a column-major walk selected by transpose_i.
module operand_mat_streamer #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_DIM    = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int DIM_W      = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [DIM_W-1:0] n_rows_i,
  input  logic [DIM_W-1:0] n_cols_i,
  input  logic             transpose_i,
  operand_mat_streamer_if.master bus,
  output logic             busy_o,
  output logic             done_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  row_last;
    logic                  last;
  } beat_t;

  localparam logic [DIM_W-1:0] DIM_MAX = DIM_W'(MAX_DIM);

  state_t           state_q, state_d;
  logic [DIM_W-1:0] rows_in, cols_in, rows_q, cols_q, row_q, col_q;
  logic             tr_in, tr_q;
  logic             issue, at_col_end, at_row_end, is_last, elem_row_last;
  logic             rd_vld, pend_row_last, pend_last;
  beat_t            fifo_q [2];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       occ_q;
  logic             push, pop;
  beat_t            head;

  assign rows_in = (n_rows_i > DIM_MAX) ? DIM_MAX : n_rows_i;
  assign cols_in = (n_cols_i > DIM_MAX) ? DIM_MAX : n_cols_i;

`ifdef TRANSPOSE_EN
  assign tr_in = transpose_i;
`else
  logic unused_transpose;
  assign unused_transpose = transpose_i;
  assign tr_in = 1'b0;
`endif

  assign at_col_end    = (col_q == cols_q - 1'b1);
  assign at_row_end    = (row_q == rows_q - 1'b1);
  assign is_last       = at_col_end && at_row_end;
  assign elem_row_last = tr_q ? at_row_end : at_col_end;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A read may only go out when its data is guaranteed a FIFO slot.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      IDLE:  if (start_i) state_d = (rows_in == '0 || cols_in == '0) ? DRAIN : ISSUE;
      ISSUE: begin
        issue = (occ_q + {1'b0, rd_vld}) < 2'd2;
        if (issue && is_last) state_d = DRAIN;
      end
      DRAIN: if (occ_q == '0 && !rd_vld) begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q != IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rows_q <= '0; cols_q <= '0; tr_q <= 1'b0;
      row_q  <= '0; col_q  <= '0;
    end else if (state_q == IDLE && start_i) begin
      rows_q <= rows_in; cols_q <= cols_in; tr_q <= tr_in;
      row_q  <= '0;      col_q  <= '0;
    end else if (issue) begin
      if (is_last) begin
        row_q <= '0; col_q <= '0;
      end else if (!tr_q) begin
        if (at_col_end) begin col_q <= '0; row_q <= row_q + 1'b1; end
        else            col_q <= col_q + 1'b1;
      end else begin
        if (at_row_end) begin row_q <= '0; col_q <= col_q + 1'b1; end
        else            row_q <= row_q + 1'b1;
      end
    end
  end

  assign bus.rd_addr = ADDR_WIDTH'(32'(row_q) * MAX_DIM + 32'(col_q));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_vld <= 1'b0; pend_row_last <= 1'b0; pend_last <= 1'b0;
    end else begin
      rd_vld <= issue;
      if (issue) begin
        pend_row_last <= elem_row_last;
        pend_last     <= is_last;
      end
    end
  end

  // Arriving data bypasses the FIFO when it is empty and the consumer takes it.
  assign pop  = (occ_q != '0) && bus.m_ready;
  assign push = rd_vld && !((occ_q == '0) && bus.m_ready);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fifo_q <= '{default: '0};
      wr_ptr <= 1'b0; rd_ptr <= 1'b0; occ_q <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= {bus.rd_data, pend_row_last, pend_last};
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    head = '0;
    if (occ_q != '0) head = fifo_q[rd_ptr];
    else if (rd_vld) head = {bus.rd_data, pend_row_last, pend_last};
  end

  assign bus.m_valid    = (occ_q != '0) || rd_vld;
  assign bus.m_data     = head.data;
  assign bus.m_row_last = head.row_last;
  assign bus.m_last     = head.last;
endmodule
